if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL provide port: imem_addr  output  32  fetch address; always equals internal pc.
REQ-006 SHALL provide port: imem_ready  input  1  imem_rdata valid this cycle for the current request.
REQ-007 SHALL provide port: imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL provide port: stall  input  1  downstream cannot accept; hold the presented instruction.
REQ-009 SHALL provide port: br_taken  input  1  redirect request (Branch AND zero from the execute stage).
REQ-010 SHALL provide port: br_target  input  32  redirect address.
REQ-011 SHALL provide port: instr_valid  output  1  decoded fields below are valid.
REQ-012 SHALL provide ports: opcode  output  6  IR[31:26]; rs  output  5  IR[25:21]; rt  output  5  IR[20:16]; rd  output  5  IR[15:11].
REQ-013 SHALL provide ports: funct  output  6  IR[5:0]; imm  output  16  IR[15:0]; pc_plus4  output  32  address of presented instruction + 4.

Function
REQ-014 SHALL implement a 3-state FSM: BOOT, FETCH, REDIRECT.
REQ-015 BOOT: imem_req=0; unconditional transition to FETCH next cycle.
REQ-016 FETCH: imem_req = NOT(instr_valid AND stall).
REQ-017 Accept = imem_req AND imem_ready in FETCH with br_taken=0; on accept: IR<=imem_rdata, pc_plus4<=pc+4, pc<=pc+4, instr_valid<=1 next edge.
REQ-018 In FETCH without accept: if stall=0, instr_valid<=0 (instruction consumed); if stall=1, IR, pc_plus4, instr_valid held.
REQ-019 Back-to-back accepts with stall=0 SHALL yield one instruction per cycle, 1-cycle latency from accept to instr_valid.
REQ-020 br_taken=1 in FETCH or REDIRECT SHALL have priority over accept and stall: pc<={br_target[31:2],2'b00}, state<=REDIRECT, any imem_rdata that cycle discarded.
REQ-021 br_taken in BOOT SHALL be ignored.
REQ-022 REDIRECT: imem_req=0 for exactly one cycle, then FETCH (unless br_taken again, which reloads pc and stays REDIRECT).
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc[1:0] always 2'b00.
REQ-024 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-025 rst=1 SHALL immediately set: state=BOOT, pc=RESET_PC, IR=0, pc_plus4=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC.
REQ-026 rst asserted mid-fetch or mid-redirect SHALL discard all in-flight data; first request after release is to RESET_PC, one cycle after BOOT.

Configuration
REQ-027 Macro IF_BRANCH_FLUSH_EN: when defined, br_taken=1 SHALL clear instr_valid next edge (presented instruction squashed, no delay slot).
REQ-028 When IF_BRANCH_FLUSH_EN undefined, br_taken SHALL not affect instr_valid/IR (delay-slot semantics; presented instruction retires per REQ-018); all else identical.

Verification
REQ-029 Reset release, imem_ready=1, stall=0, rdata=32'h0000_0020,32'h2008_0005 -> imem_addr 0,4,8; instr_valid from 2nd cycle after BOOT; opcode 6'h00/funct 6'h20 then opcode 6'h08/imm 16'h0005; pc_plus4 4 then 8.
REQ-030 stall=1 for 3 cycles with instr_valid=1 -> imem_req=0, outputs frozen; stall=0 -> fetch resumes at next sequential pc, no instruction lost or duplicated.
REQ-031 br_taken=1, br_target=32'h0000_0103 while imem_ready=1 -> rdata discarded, one REDIRECT cycle with imem_req=0, next imem_addr=32'h0000_0100; instr_valid=0 next cycle with IF_BRANCH_FLUSH_EN, retained per REQ-028 without.
REQ-032 RESET_PC=32'hFFFF_FFFC, imem_ready=1 -> second fetch address 32'h0000_0000.
REQ-033 rst pulse asserted asynchronously mid-cycle during FETCH with instr_valid=1 -> instr_valid, imem_req drop to 0 before next clock edge; refetch from RESET_PC after release.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, pipeline control and decoded outputs.
// Handshake: a fetch completes on a cycle where imem_req and imem_ready are both high; imem_ready with imem_req low is ignored; instr_valid with stall high holds the presented instruction.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_plus4;
  logic [1:0]  dbg_state;

  modport master (
    output imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, funct, imm, pc_plus4, dbg_state,
    input  imem_ready, imem_rdata, stall, br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, funct, imm, pc_plus4, dbg_state,
    output imem_ready, imem_rdata, stall, br_taken, br_target
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/FETCH/REDIRECT FSM, pc sequencing, instruction register and field decode.
// Optional macro IF_BRANCH_FLUSH_EN squashes the presented instruction on a taken branch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        req;
  logic        accept;
  logic [31:0] pc_inc;

  // Request drops only while a presented instruction is being held.
  assign req    = (state_q == FETCH) && !(valid_q && bus.stall);
  assign accept = req && bus.imem_ready && !bus.br_taken;
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, REDIRECT: begin
        if (bus.br_taken) begin
          pc_d    = {bus.br_target[31:2], 2'b00};
          state_d = REDIRECT;
`ifdef IF_BRANCH_FLUSH_EN
          valid_d = 1'b0;
`else
          if (!bus.stall) valid_d = 1'b0;
`endif
        end else begin
          state_d = FETCH;
          if (accept) begin
            ir_d       = bus.imem_rdata;
            pc_d       = pc_inc;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
          end else if (!bus.stall) begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC_AL;
      ir_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = ir_q[31:26];
  assign bus.rs          = ir_q[25:21];
  assign bus.rt          = ir_q[20:16];
  assign bus.rd          = ir_q[15:11];
  assign bus.funct       = ir_q[5:0];
  assign bus.imm         = ir_q[15:0];
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/branch/reset sequences with a scoreboard of retired instructions.
// A second instance with RESET_PC=32'hFFFF_FFFC covers pc wrap-around.
module tb_if_stage;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        squash;

  if_stage_if bus();
  if_stage_if wbus();

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0020;
      32'h0000_0004: mem_word = 32'h2008_0005;
      32'h0000_0008: mem_word = 32'h8C43_0010;
      32'h0000_000C: mem_word = 32'h0085_1020;
      32'h0000_0010: mem_word = 32'hAC62_0008;
      32'h0000_0100: mem_word = 32'h1000_FFFF;
      default:       mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign bus.imem_rdata  = mem_word(bus.imem_addr);
  assign wbus.imem_rdata = 32'h1234_5678;
  assign wbus.imem_ready = 1'b1;
  assign wbus.stall      = 1'b0;
  assign wbus.br_taken   = 1'b0;
  assign wbus.br_target  = 32'h0;

`ifdef IF_BRANCH_FLUSH_EN
  assign squash = bus.br_taken;
`else
  assign squash = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] word, input logic [31:0] pc4);
    exp_q.push_back({word, pc4});
  endtask

  // scoreboard monitor: an instruction retires when presented with stall low
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && !bus.stall && !squash) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr: got word %h pc_plus4 %h, expected none",
                 {bus.opcode, bus.rs, bus.rt, bus.imm}, bus.pc_plus4);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr_word", {bus.opcode, bus.rs, bus.rt, bus.imm}, mon_e[63:32]);
        chk("rd_funct", {21'd0, bus.rd, bus.funct}, {21'd0, mon_e[47:43], mon_e[37:32]});
        chk("pc_plus4", bus.pc_plus4, mon_e[31:0]);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 32'h0;
    bus.imem_ready = 1'b1;
    #1;
    chk("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_pc4", bus.pc_plus4, 32'h0);
    chk("rst_ir", {bus.opcode, bus.rs, bus.rt, bus.imm}, 32'h0);
    chk("wrap_rst_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
    chk("boot_state", {30'd0, bus.dbg_state}, 32'd0);

    // sequential fetch
    push(32'h0000_0020, 32'h4);
    push(32'h2008_0005, 32'h8);
    cyc();
    chk("f0_state", {30'd0, bus.dbg_state}, 32'd1);
    chk("f0_req", {31'd0, bus.imem_req}, 32'd1);
    chk("f0_addr", bus.imem_addr, 32'h0);
    chk("f0_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("wrap_f0_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("f1_addr", bus.imem_addr, 32'h4);
    chk("f1_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("wrap_f1_addr", wbus.imem_addr, 32'h0);
    chk("wrap_f1_pc4", wbus.pc_plus4, 32'h0);
    chk("wrap_f1_valid", {31'd0, wbus.instr_valid}, 32'd1);
    cyc();
    chk("f2_addr", bus.imem_addr, 32'h8);

    // stall for three cycles with an instruction presented
    bus.stall = 1'b1;
    #1;
    chk("stall_req0", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h8);
      chk("stall_pc4", bus.pc_plus4, 32'h8);
    end
    bus.stall = 1'b0;
    push(32'h8C43_0010, 32'hC);
    cyc();
    chk("resume_addr", bus.imem_addr, 32'hC);
`ifndef IF_BRANCH_FLUSH_EN
    push(32'h0085_1020, 32'h10);
`endif
    cyc();
    chk("resume_addr2", bus.imem_addr, 32'h10);

    // taken branch while imem_ready is high
    bus.br_taken = 1'b1;
    bus.br_target = 32'h0000_0103;
    cyc();
    bus.br_taken = 1'b0;
    #1;
    chk("redir_state", {30'd0, bus.dbg_state}, 32'd2);
    chk("redir_req", {31'd0, bus.imem_req}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_valid", {31'd0, bus.instr_valid}, 32'd0);
    cyc();
    chk("post_redir_state", {30'd0, bus.dbg_state}, 32'd1);
    chk("post_redir_req", {31'd0, bus.imem_req}, 32'd1);
    chk("post_redir_addr", bus.imem_addr, 32'h100);
`ifndef IF_BRANCH_FLUSH_EN
    push(32'h1000_FFFF, 32'h104);
`endif
    cyc();
    chk("tgt_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("tgt_pc4", bus.pc_plus4, 32'h104);

    // branch taken while stalled: squashed or held depending on build
    bus.stall = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 32'h0000_0010;
    cyc();
`ifdef IF_BRANCH_FLUSH_EN
    chk("br_stall_valid", {31'd0, bus.instr_valid}, 32'd0);
`else
    chk("br_stall_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("br_stall_pc4", bus.pc_plus4, 32'h104);
`endif
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    #1;
    chk("br_stall_req", {31'd0, bus.imem_req}, 32'd0);
    chk("br_stall_state", {30'd0, bus.dbg_state}, 32'd2);
    chk("br_stall_addr", bus.imem_addr, 32'h10);
    cyc();
    chk("refetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("refetch_addr", bus.imem_addr, 32'h10);
    chk("refetch_valid", {31'd0, bus.instr_valid}, 32'd0);
    push(32'hAC62_0008, 32'h14);
    cyc();
    chk("refetch_valid1", {31'd0, bus.instr_valid}, 32'd1);
    chk("refetch_addr1", bus.imem_addr, 32'h14);

    // imem_ready low: no accept, instruction consumed
    bus.imem_ready = 1'b0;
    cyc();
    chk("noready_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("noready_addr", bus.imem_addr, 32'h14);
    bus.imem_ready = 1'b1;
`ifndef IF_BRANCH_FLUSH_EN
    push(32'hC0DE_0014, 32'h18);
`endif
    cyc();
    chk("ready_addr", bus.imem_addr, 32'h18);
    chk("ready_pc4", bus.pc_plus4, 32'h18);

    // back-to-back branches keep the stage in REDIRECT
    bus.br_taken = 1'b1;
    bus.br_target = 32'h0000_0200;
    cyc();
    chk("bb1_addr", bus.imem_addr, 32'h200);
    chk("bb1_state", {30'd0, bus.dbg_state}, 32'd2);
    chk("bb1_valid", {31'd0, bus.instr_valid}, 32'd0);
    bus.br_target = 32'h0000_0301;
    cyc();
    chk("bb2_addr", bus.imem_addr, 32'h300);
    chk("bb2_state", {30'd0, bus.dbg_state}, 32'd2);
    chk("bb2_req", {31'd0, bus.imem_req}, 32'd0);
    bus.br_taken = 1'b0;
    cyc();
    chk("bb3_state", {30'd0, bus.dbg_state}, 32'd1);
    chk("bb3_addr", bus.imem_addr, 32'h300);
    chk("bb3_req", {31'd0, bus.imem_req}, 32'd1);
    cyc();
    chk("bb4_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("bb4_pc4", bus.pc_plus4, 32'h304);

    // asynchronous reset mid-cycle with an instruction presented
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_state", {30'd0, bus.dbg_state}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    push(32'h0000_0020, 32'h4);
    cyc();
    chk("rf_state", {30'd0, bus.dbg_state}, 32'd1);
    chk("rf_addr", bus.imem_addr, 32'h0);
    chk("rf_req", {31'd0, bus.imem_req}, 32'd1);
    cyc();
    chk("rf_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("rf_addr1", bus.imem_addr, 32'h4);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cyc();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
